uart_tx_fifo: RTL and testbench

// - Byte buffer and launch sequencer directly upstream of uart_tx.
// - Accepts bytes from the host/CPU side, queues up to DEPTH of them, and feeds them
//   one at a time into uart_tx through its data/data_valid/tx_busy handshake.
// - Lets producers burst writes without tracking the serial line, which runs at 9600 baud.

---
 rtl/uart_tx_fifo_pkg.sv | 15 +
 rtl/uart_tx_fifo_mem.sv | 37 +++
 rtl/uart_tx_fifo.sv | 113 +++++++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO and its neighbours.
package uart_tx_fifo_pkg;

  // Baud divisor shared with uart_tx/uart_rx: 50 MHz clock, 9600 baud, 16x oversampling.
  localparam int unsigned DIVISOR = 326;

  // Read-side launch sequencer states.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } rd_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// FIFO storage: DEPTH x 8 register array, one write port, one registered read port.
// Storage itself is not reset; only the read register is.
module uart_tx_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value between reads so the output byte stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue and launch sequencer feeding uart_tx through data/data_valid/tx_busy.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      wr_data,
  input  logic            wr_en,
  input  logic            clr_overflow,
  input  logic            tx_busy,
  output logic [7:0]      tx_data,
  output logic            tx_data_valid,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow
);

  localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PtrOne    = (ADDR_W + 1)'(1);

  rd_state_e       state;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            pop;
  logic            push;
  logic            drop;

  assign full  = (count == CountFull);
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a write while full is still accepted then.
  assign pop  = (state == StIdle) && !empty && !tx_busy;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  uart_tx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (tx_data)
  );

  // Pointers and occupancy; pointers carry a wrap bit and roll over modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;
      unique case ({push, pop})
        2'b10:   count <= count + PtrOne;
        2'b01:   count <= count - PtrOne;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Launch sequencer: one-cycle data_valid pulse, then track uart_tx busy until the frame ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= StIdle;
      tx_data_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pop) begin
            tx_data_valid <= 1'b1;
            state         <= StLaunch;
          end
        end
        StLaunch: begin
          tx_data_valid <= 1'b0;
          state         <= StWaitBusy;
        end
        StWaitBusy: begin
          if (tx_busy) state <= StWaitDone;
        end
        StWaitDone: begin
          if (!tx_busy) state <= StIdle;
        end
        default: begin
          tx_data_valid <= 1'b0;
          state         <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with a behavioural uart_tx busy stub and a byte scoreboard.
module tb_uart_tx_fifo;

  localparam int unsigned StubBusy = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       force_busy = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;

  int unsigned stub_cnt = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          pulses = 0;
  int          p0 = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  last_data = 8'h00;
  logic [7:0]  sb [$];

  uart_tx_fifo #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .clr_overflow  (clr_overflow),
    .tx_busy       (tx_busy),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy from the cycle after it samples data_valid; never reset.
  always @(posedge clk) begin
    if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
    else if (tx_data_valid) stub_cnt <= StubBusy;
  end
  assign tx_busy = force_busy || (stub_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every pulse: single cycle, line idle, byte matches scoreboard head.
  always @(negedge clk) begin
    if (tx_data_valid) begin
      pulses++;
      check("pulse_single_cycle", {31'd0, prev_valid}, 0);
      check("pulse_line_idle", {31'd0, tx_busy}, 0);
      check("pulse_expected", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) check("tx_data_order", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      last_data = tx_data;
    end
    prev_valid = tx_data_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    int stable = 0;
    while (stable < 4 && n < 3000) begin
      tick();
      n++;
      if (empty && !tx_busy && !tx_data_valid) stable++;
      else stable = 0;
    end
    check(tag, {31'd0, n < 3000}, 1);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_count", {27'd0, count}, 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_valid", {31'd0, tx_data_valid}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    rst_n = 1'b1;
    tick();

    // 1: single byte, one-cycle latency to the pulse
    sb.push_back(8'hA5);
    write(8'hA5);
    check("s1_count_after_write", {27'd0, count}, 1);
    check("s1_no_fallthrough", {31'd0, tx_data_valid}, 0);
    tick();
    check("s1_valid", {31'd0, tx_data_valid}, 1);
    check("s1_tx_data", {24'd0, tx_data}, 32'hA5);
    check("s1_count_after_pop", {27'd0, count}, 0);
    check("s1_empty", {31'd0, empty}, 1);
    tick();
    check("s1_pulse_end", {31'd0, tx_data_valid}, 0);
    wait_drain("s1_drain");
    check("s1_pulses", pulses, 1);

    // 2: 16-byte burst, first byte pops during the burst
    p0 = pulses;
    for (int i = 1; i <= 16; i++) begin
      sb.push_back(8'(i));
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("s2_count", {27'd0, count}, 15);
    check("s2_full", {31'd0, full}, 0);
    check("s2_overflow", {31'd0, overflow}, 0);
    wait_drain("s2_drain");
    check("s2_pulses", pulses - p0, 16);
    check("s2_sb_empty", sb.size(), 0);
    check("s2_overflow_end", {31'd0, overflow}, 0);

    // 3: fill while the line is held busy, then overflow handling
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      sb.push_back(8'(32'h20 + i));
      write(8'(32'h20 + i));
    end
    check("s3_count_full", {27'd0, count}, 16);
    check("s3_full", {31'd0, full}, 1);
    write(8'hFF);
    check("s3_overflow_set", {31'd0, overflow}, 1);
    check("s3_count_after_drop", {27'd0, count}, 16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("s3_overflow_clr", {31'd0, overflow}, 0);
    clr_overflow = 1'b1;
    write(8'hFF);
    clr_overflow = 1'b0;
    check("s3_set_wins", {31'd0, overflow}, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("s3_overflow_clr2", {31'd0, overflow}, 0);
    check("s3_count_held", {27'd0, count}, 16);

    // 4: write while full in the same cycle as a pop
    force_busy = 1'b0;
    sb.push_back(8'h77);
    write(8'h77);
    check("s4_valid", {31'd0, tx_data_valid}, 1);
    check("s4_first_byte", {24'd0, tx_data}, 32'h20);
    check("s4_count", {27'd0, count}, 16);
    check("s4_full", {31'd0, full}, 1);
    check("s4_no_overflow", {31'd0, overflow}, 0);
    wait_drain("s4_drain");
    check("s4_sb_empty", sb.size(), 0);
    check("s4_last_byte", {24'd0, last_data}, 32'h77);

    // 5: reset mid-frame flushes the queue; uart_tx keeps running
    for (int i = 0; i < 6; i++) begin
      sb.push_back(8'(32'h40 + i));
      write(8'(32'h40 + i));
    end
    check("s5_count", {27'd0, count}, 5);
    check("s5_line_busy", {31'd0, tx_busy}, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check("s5_rst_count", {27'd0, count}, 0);
    check("s5_rst_empty", {31'd0, empty}, 1);
    check("s5_rst_valid", {31'd0, tx_data_valid}, 0);
    check("s5_frame_continues", {31'd0, tx_busy}, 1);
    sb.push_back(8'h3C);
    write(8'h3C);
    begin
      int n = 0;
      while (!tx_data_valid && n < 200) begin
        tick();
        n++;
      end
      check("s5_pulse_seen", {31'd0, tx_data_valid}, 1);
      check("s5_tx_data", {24'd0, tx_data}, 32'h3C);
    end
    wait_drain("s5_drain");
    check("s5_sb_empty", sb.size(), 0);

    // 6: busy held externally keeps the FSM waiting; release gives a pulse one cycle later
    p0 = pulses;
    sb.push_back(8'h5A);
    write(8'h5A);
    tick();
    tick();
    force_busy = 1'b1;
    sb.push_back(8'h6B);
    write(8'h6B);
    repeat (40) tick();
    check("s6_held_pulses", pulses - p0, 1);
    check("s6_held_count", {27'd0, count}, 1);
    force_busy = 1'b0;
    tick();
    check("s6_release_wait", {31'd0, tx_data_valid}, 0);
    tick();
    check("s6_release_pulse", {31'd0, tx_data_valid}, 1);
    check("s6_tx_data", {24'd0, tx_data}, 32'h6B);
    wait_drain("s6_drain");
    check("s6_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
